// File: rtl/p2p_cfg_responder.sv
// Target-side P2P cfg endpoint: streamed multi-qword register writes and single-qword reads.
// Optional error counter port err_cnt is enabled by defining P2P_CFG_ERR_CNT_EN.
module p2p_cfg_responder #(
    parameter int unsigned DATA_W  = 256,
    parameter int unsigned HEAD_W  = 128,
    parameter int unsigned REG_NUM = 32,
    parameter int unsigned ADDR_W  = 13
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p2p_cfg_req_valid,
    input  logic                  p2p_cfg_req_last,
    input  logic [DATA_W-1:0]     p2p_cfg_req_data,
    input  logic [HEAD_W-1:0]     p2p_cfg_req_head,
    output logic                  p2p_cfg_req_ready,
    output logic                  p2p_cfg_rrsp_valid,
    output logic                  p2p_cfg_rrsp_last,
    output logic [DATA_W-1:0]     p2p_cfg_rrsp_data,
    input  logic                  p2p_cfg_rrsp_ready,
    output logic [REG_NUM*64-1:0] cfg_reg_out,
`ifdef P2P_CFG_ERR_CNT_EN
    output logic [15:0]           err_cnt,
`endif
    output logic [REG_NUM-1:0]    cfg_wr_pulse
);
    localparam int unsigned LANES  = DATA_W / 64;
    localparam int unsigned RIDX_W = $clog2(REG_NUM);
    localparam int unsigned IDX_W  = ADDR_W - 2;
    localparam int unsigned CNT_W  = 11;

    typedef enum logic [1:0] {S_IDLE, S_WR, S_RD_DRAIN, S_RD_RSP} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [63:0]         r_regs [REG_NUM];
    logic [IDX_W-1:0]    r_cur_idx;
    logic [CNT_W-1:0]    r_rem;
    logic                r_req_ready;
    logic                r_rsp_valid;
    logic [63:0]         r_rsp_q;
    logic [REG_NUM-1:0]  r_wr_pulse;

    logic                w_beat;
    logic                w_is_wr;
    logic [12:0]         w_len;
    logic [IDX_W-1:0]    w_start_idx;
    logic [CNT_W-1:0]    w_head_cnt;
    logic [IDX_W-1:0]    w_base_idx;
    logic [CNT_W-1:0]    w_base_cnt;
    logic [CNT_W-1:0]    w_used;
    logic                w_wr_act;
    logic [LANES-1:0]    w_lane_we;
    logic [IDX_W-1:0]    w_lane_idx [LANES];
    logic [REG_NUM-1:0]  w_wr_mask;
    logic [63:0]         w_rd_q;
    logic                w_unused_head;

    assign w_beat        = p2p_cfg_req_valid & r_req_ready;
    assign w_is_wr       = p2p_cfg_req_head[127];
    assign w_len         = p2p_cfg_req_head[12:0];
    assign w_start_idx   = IDX_W'(p2p_cfg_req_head[32+ADDR_W-1:35]);
    assign w_head_cnt    = CNT_W'((14'(w_len) + 14'd7) >> 3);
    assign w_unused_head = ^p2p_cfg_req_head;

    // First beat takes its window from the head; later write beats continue from the saved cursor.
    assign w_base_idx = (r_state == S_IDLE) ? w_start_idx : r_cur_idx;
    assign w_base_cnt = (r_state == S_IDLE) ? w_head_cnt : r_rem;
    assign w_used     = (w_base_cnt > CNT_W'(LANES)) ? CNT_W'(LANES) : w_base_cnt;
    assign w_wr_act   = w_beat && (((r_state == S_IDLE) && w_is_wr) || (r_state == S_WR));

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_beat) begin
                    if (w_is_wr) begin
                        w_state_nxt = p2p_cfg_req_last ? S_IDLE : S_WR;
                    end else begin
                        w_state_nxt = p2p_cfg_req_last ? S_RD_RSP : S_RD_DRAIN;
                    end
                end
            end
            S_WR: begin
                if (w_beat && p2p_cfg_req_last) w_state_nxt = S_IDLE;
            end
            S_RD_DRAIN: begin
                if (w_beat && p2p_cfg_req_last) w_state_nxt = S_RD_RSP;
            end
            S_RD_RSP: begin
                if (p2p_cfg_rrsp_ready) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Lane write enables and per-register write mask
    always_comb begin
        w_lane_we = '0;
        w_wr_mask = '0;
        w_rd_q    = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            w_lane_idx[k] = w_base_idx + IDX_W'(k);
            w_lane_we[k]  = w_wr_act && (CNT_W'(k) < w_base_cnt)
                            && (w_lane_idx[k] < IDX_W'(REG_NUM));
            if (w_lane_we[k]) w_wr_mask[w_lane_idx[k][RIDX_W-1:0]] = 1'b1;
        end
        if (w_start_idx < IDX_W'(REG_NUM)) w_rd_q = r_regs[w_start_idx[RIDX_W-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < REG_NUM; i++) r_regs[i] <= '0;
            r_cur_idx   <= '0;
            r_rem       <= '0;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_q     <= '0;
            r_wr_pulse  <= '0;
        end else begin
            for (int unsigned k = 0; k < LANES; k++) begin
                if (w_lane_we[k]) r_regs[w_lane_idx[k][RIDX_W-1:0]] <= p2p_cfg_req_data[64*k +: 64];
            end
            if (w_wr_act) begin
                r_cur_idx <= w_base_idx + IDX_W'(LANES);
                r_rem     <= w_base_cnt - w_used;
            end
            if ((r_state == S_IDLE) && w_beat && !w_is_wr) begin
                r_rsp_q <= w_rd_q;
            end else if ((r_state == S_RD_RSP) && p2p_cfg_rrsp_ready) begin
                r_rsp_q <= '0;
            end
            r_req_ready <= (w_state_nxt != S_RD_RSP);
            r_rsp_valid <= (w_state_nxt == S_RD_RSP);
            r_wr_pulse  <= w_wr_mask;
        end
    end

`ifdef P2P_CFG_ERR_CNT_EN
    logic [15:0]      r_err_cnt;
    logic [IDX_W-1:0] w_last_idx;
    logic             w_err;

    // A write is out of range if its final qword lands past the bank.
    assign w_last_idx = w_start_idx + ((w_head_cnt == '0) ? '0 : IDX_W'(w_head_cnt - CNT_W'(1)));
    assign w_err = w_beat && (r_state == S_IDLE)
                   && (((w_is_wr ? w_last_idx : w_start_idx) >= IDX_W'(REG_NUM))
                       || (!w_is_wr && ((w_len != 13'd8) || !p2p_cfg_req_last)));

    always_ff @(posedge clk) begin
        if (rst)                             r_err_cnt <= '0;
        else if (w_err && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + 16'd1;
    end

    assign err_cnt = r_err_cnt;
`endif

    for (genvar g = 0; g < REG_NUM; g++) begin : g_reg_out
        assign cfg_reg_out[64*g +: 64] = r_regs[g];
    end

    assign p2p_cfg_req_ready  = r_req_ready;
    assign p2p_cfg_rrsp_valid = r_rsp_valid;
    assign p2p_cfg_rrsp_last  = r_rsp_valid;
    assign p2p_cfg_rrsp_data  = DATA_W'(r_rsp_q);
    assign cfg_wr_pulse       = r_wr_pulse;

endmodule

// File: tb/tb_p2p_cfg_responder.sv
// Scoreboard bench for p2p_cfg_responder: directed writes/reads, response queue checked by a monitor.
module tb_p2p_cfg_responder;
    localparam int unsigned DATA_W  = 256;
    localparam int unsigned HEAD_W  = 128;
    localparam int unsigned REG_NUM = 32;
    localparam int unsigned ADDR_W  = 13;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  req_valid;
    logic                  req_last;
    logic [DATA_W-1:0]     req_data;
    logic [HEAD_W-1:0]     req_head;
    logic                  req_ready;
    logic                  rrsp_valid;
    logic                  rrsp_last;
    logic [DATA_W-1:0]     rrsp_data;
    logic                  rrsp_ready;
    logic [REG_NUM*64-1:0] reg_out;
    logic [REG_NUM-1:0]    wr_pulse;
`ifdef P2P_CFG_ERR_CNT_EN
    logic [15:0]           err_cnt;
`endif

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [63:0] exp_q[$];
    logic [63:0] m_regs [REG_NUM];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    p2p_cfg_responder #(
        .DATA_W(DATA_W), .HEAD_W(HEAD_W), .REG_NUM(REG_NUM), .ADDR_W(ADDR_W)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .p2p_cfg_req_valid  (req_valid),
        .p2p_cfg_req_last   (req_last),
        .p2p_cfg_req_data   (req_data),
        .p2p_cfg_req_head   (req_head),
        .p2p_cfg_req_ready  (req_ready),
        .p2p_cfg_rrsp_valid (rrsp_valid),
        .p2p_cfg_rrsp_last  (rrsp_last),
        .p2p_cfg_rrsp_data  (rrsp_data),
        .p2p_cfg_rrsp_ready (rrsp_ready),
        .cfg_reg_out        (reg_out),
`ifdef P2P_CFG_ERR_CNT_EN
        .err_cnt            (err_cnt),
`endif
        .cfg_wr_pulse       (wr_pulse)
    );

    function automatic logic [HEAD_W-1:0] mk_head(input logic is_wr, input logic [31:0] addr,
                                                  input logic [12:0] len);
        logic [HEAD_W-1:0] h;
        h        = '0;
        h[127]   = is_wr;
        h[63:32] = addr;
        h[12:0]  = len;
        return h;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < int'(REG_NUM); i++)
            chk($sformatf("%s_reg%0d", tag, i), reg_out[64*i +: 64], m_regs[i]);
    endtask

    // Called at a negedge; returns at the negedge right after the accepting posedge.
    task automatic send_beat(input logic [HEAD_W-1:0] h, input logic [DATA_W-1:0] d,
                             input logic last, output int acc);
        int n;
        n = 0;
        req_valid = 1'b1;
        req_head  = h;
        req_data  = d;
        req_last  = last;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("req_accept_timeout", 64'(n < 100), 64'd1);
        acc = cyc;
        @(negedge clk);
        req_valid = 1'b0;
        req_last  = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_pending", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic set_rrdy(input logic v);
        @(posedge clk);
        #1 rrsp_ready = v;
        @(negedge clk);
    endtask

    // Response monitor: compares every presented response against the queue head.
    always @(negedge clk) begin
        if (!rst && rrsp_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got data %h expected no response", rrsp_data[63:0]);
            end else begin
                chk("rsp_data", rrsp_data[63:0], exp_q[0]);
                chk("rsp_upper", 64'(|rrsp_data[DATA_W-1:64]), 64'd0);
                chk("rsp_last", 64'(rrsp_last), 64'd1);
                if (rrsp_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int          a1, a2, dummy;
        logic [DATA_W-1:0] d;

        rst = 1'b1; req_valid = 1'b0; req_last = 1'b0; req_data = '0; req_head = '0;
        rrsp_ready = 1'b1;
        for (int i = 0; i < int'(REG_NUM); i++) m_regs[i] = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_rrsp_valid", 64'(rrsp_valid), 64'd0);
        chk("rst_rrsp_data", rrsp_data[63:0], 64'd0);
        chk("rst_wr_pulse", 64'(wr_pulse), 64'd0);
        check_regs("rst");

        // Single-qword write to reg2
        d = '0; d[63:0] = 64'hA5A5_0000_1234_5678;
        send_beat(mk_head(1'b1, 32'h10, 13'd8), d, 1'b1, dummy);
        chk("t1_pulse", 64'(wr_pulse), 64'h4);
        m_regs[2] = 64'hA5A5_0000_1234_5678;
        check_regs("t1");
        @(negedge clk);
        chk("t1_pulse_clear", 64'(wr_pulse), 64'h0);

        // Read reg2 with response backpressure
        rrsp_ready = 1'b0;
        exp_q.push_back(64'hA5A5_0000_1234_5678);
        send_beat(mk_head(1'b0, 32'h10, 13'd8), '0, 1'b1, dummy);
        for (int i = 0; i < 3; i++) begin
            chk("t3_valid_held", 64'(rrsp_valid), 64'd1);
            chk("t3_req_ready_low", 64'(req_ready), 64'd0);
            if (i < 2) @(negedge clk);
        end
        set_rrdy(1'b1);
        @(negedge clk);
        chk("t3_valid_drop", 64'(rrsp_valid), 64'd0);
        chk("t3_data_zero", rrsp_data[63:0], 64'd0);
        chk("t3_req_ready_back", 64'(req_ready), 64'd1);
        chk("t3_q_empty", 64'(exp_q.size()), 64'd0);

        // Two-beat write of qwords 0..5; extra lanes beyond the count are dropped
        d = {64'hBEEF, 64'hDEAD, 64'd6, 64'd5};
        send_beat(mk_head(1'b1, 32'h0, 13'd48), {64'd4, 64'd3, 64'd2, 64'd1}, 1'b0, dummy);
        chk("t2_pulse_b1", 64'(wr_pulse), 64'hF);
        send_beat(mk_head(1'b1, 32'h0, 13'd48), d, 1'b1, dummy);
        chk("t2_pulse_b2", 64'(wr_pulse), 64'h30);
        for (int i = 0; i < 6; i++) m_regs[i] = 64'(i + 1);
        check_regs("t2");

        // Read immediately after a write to the same register
        d = '0; d[63:0] = 64'h7777_7777;
        send_beat(mk_head(1'b1, 32'h38, 13'd8), d, 1'b1, dummy);
        m_regs[7] = 64'h7777_7777;
        exp_q.push_back(64'h7777_7777);
        send_beat(mk_head(1'b0, 32'h38, 13'd8), '0, 1'b1, dummy);
        wait_drain();
        exp_q.push_back(64'd6);
        send_beat(mk_head(1'b0, 32'h28, 13'd8), '0, 1'b1, dummy);
        wait_drain();

        // Write at the top of the bank; second qword falls off the end
        d = '0; d[63:0] = 64'h3131_3131_3131_3131; d[127:64] = 64'h1111;
        send_beat(mk_head(1'b1, 32'hF8, 13'd16), d, 1'b1, dummy);
        chk("t4_pulse", 64'(wr_pulse), 64'h8000_0000);
        m_regs[31] = 64'h3131_3131_3131_3131;
        check_regs("t4");
        exp_q.push_back(64'd0);
        send_beat(mk_head(1'b0, 32'h100, 13'd8), '0, 1'b1, dummy);
        wait_drain();
`ifdef P2P_CFG_ERR_CNT_EN
        chk("t4_err_cnt", 64'(err_cnt), 64'd2);
`endif

        // Two-beat read: trailing beat is drained, one response returned
        exp_q.push_back(64'd2);
        send_beat(mk_head(1'b0, 32'h8, 13'd8), '0, 1'b0, dummy);
        chk("drain_no_rsp", 64'(rrsp_valid), 64'd0);
        send_beat(mk_head(1'b0, 32'h8, 13'd8), '0, 1'b1, dummy);
        wait_drain();
`ifdef P2P_CFG_ERR_CNT_EN
        chk("drain_err_cnt", 64'(err_cnt), 64'd3);
`endif

        // Reset in the middle of a three-beat write
        send_beat(mk_head(1'b1, 32'h0, 13'd96), {64'hD, 64'hC, 64'hB, 64'hA}, 1'b0, dummy);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < int'(REG_NUM); i++) m_regs[i] = '0;
        chk("t5_req_ready", 64'(req_ready), 64'd1);
        chk("t5_rrsp_valid", 64'(rrsp_valid), 64'd0);
        check_regs("t5");
`ifdef P2P_CFG_ERR_CNT_EN
        chk("t5_err_cnt", 64'(err_cnt), 64'd0);
`endif
        d = '0; d[63:0] = 64'h99;
        send_beat(mk_head(1'b1, 32'h18, 13'd8), d, 1'b1, dummy);
        chk("t5_pulse", 64'(wr_pulse), 64'h8);
        m_regs[3] = 64'h99;
        check_regs("t5_fresh");

        // Back-to-back reads: second accepted only after the first response handshake
        exp_q.push_back(64'h99);
        exp_q.push_back(64'd0);
        send_beat(mk_head(1'b0, 32'h18, 13'd8), '0, 1'b1, a1);
        send_beat(mk_head(1'b0, 32'h0, 13'd8), '0, 1'b1, a2);
        chk("t6_turnaround", 64'(a2 - a1), 64'd2);
        wait_drain();
        @(negedge clk);
        chk("end_rrsp_valid", 64'(rrsp_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
